// File: rtl/midi_pkg.sv
// Shared MIDI constants, voice slot record and UART state encoding.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF   = 4'h8;
  localparam logic [3:0] NOTE_ON    = 4'h9;
  localparam logic [3:0] CTRL       = 4'hB;
  localparam logic [3:0] PROG       = 4'hC;
  localparam logic [3:0] CHAN_PRESS = 4'hD;

  localparam logic [6:0] CC_SUSTAIN       = 7'd64;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  // Wide enough for an age saturating at 31 (NUM_VOICES up to 32)
  localparam int unsigned AGE_W = 5;

  typedef struct packed {
    logic             on;
    logic             sustained;
    logic [6:0]       note;
    logic [6:0]       vel;
    logic [AGE_W-1:0] age;
  } voice_t;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

  // Program change and channel pressure carry one data byte, the rest two
  function automatic logic is_one_data(input logic [3:0] kind);
    return (kind == PROG) || (kind == CHAN_PRESS);
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// MIDI serial input: 2-FF synchroniser plus 8N1 UART receiver.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE        = 31_250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned BIT   = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HALF  = BIT / 2;
  localparam int unsigned CNT_W = $clog2(BIT + 1);

  logic [1:0]       sync_q;
  logic             rx;
  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  assign rx         = sync_q[1];
  assign byte_data  = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

  // Synchronise the asynchronous line; idle level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], data_in};
  end

  // Receiver state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= UART_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Bit timing, start glitch rejection, LSB-first shift, stop check
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      UART_IDLE: begin
        if (!rx) begin
          state_d = UART_START;
          cnt_d   = '0;
        end
      end
      UART_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d = '0;
          if (!rx) begin
            state_d   = UART_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = UART_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UART_DATA: begin
        if (cnt_q == CNT_W'(BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = UART_STOP;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UART_STOP: begin
        if (cnt_q == CNT_W'(BIT - 1)) begin
          cnt_d   = '0;
          state_d = UART_IDLE;
          if (rx) valid_d = 1'b1;
          else    ferr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = UART_IDLE;
    endcase
  end

endmodule

// File: rtl/midi_poly_rx.sv
// MIDI receiver with running-status parser and polyphonic voice allocator.
module midi_poly_rx
  import midi_pkg::*;
#(
  parameter int unsigned INPUT_CLOCK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE         = 31_250,
  parameter int unsigned NUM_VOICES        = 8,
  parameter int unsigned VEL_WIDTH         = 3,
  parameter int unsigned CHANNEL_FILTER_EN = 0,
  parameter int unsigned MIDI_CHANNEL      = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            data_in,
  output logic [NUM_VOICES-1:0]           on_out,
  output logic [NUM_VOICES*7-1:0]         note_out,
  output logic [NUM_VOICES*VEL_WIDTH-1:0] velocity_out,
  output logic                            sustain_out,
  output logic                            frame_err
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

  logic [7:0] byte_data;
  logic       byte_valid;

  midi_uart_rx #(
    .INPUT_CLOCK_FREQ(INPUT_CLOCK_FREQ),
    .BAUD_RATE       (BAUD_RATE)
  ) u_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  logic [7:0] status_q, status_d;
  logic       status_vld_q, status_vld_d;
  logic [6:0] data0_q, data0_d;
  logic       idx_q, idx_d;
  logic       sustain_q, sustain_d;
  voice_t     voices_q [NUM_VOICES];
  voice_t     voices_d [NUM_VOICES];

  logic       chan_ok;
  logic       exec;
  logic [6:0] d0, d1;

  assign chan_ok = (CHANNEL_FILTER_EN == 0) || (status_q[3:0] == 4'(MIDI_CHANNEL));

  // Parser and voice state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q     <= '0;
      status_vld_q <= 1'b0;
      data0_q      <= '0;
      idx_q        <= 1'b0;
      sustain_q    <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) voices_q[i] <= '0;
    end else begin
      status_q     <= status_d;
      status_vld_q <= status_vld_d;
      data0_q      <= data0_d;
      idx_q        <= idx_d;
      sustain_q    <= sustain_d;
      for (int i = 0; i < NUM_VOICES; i++) voices_q[i] <= voices_d[i];
    end
  end

  // Byte classification, running status and message completion
  always_comb begin
    status_d     = status_q;
    status_vld_d = status_vld_q;
    data0_d      = data0_q;
    idx_d        = idx_q;
    exec         = 1'b0;
    d0           = '0;
    d1           = '0;
    if (byte_valid) begin
      if (byte_data[7]) begin
        if (byte_data < 8'hF0) begin
          status_d     = byte_data;
          status_vld_d = 1'b1;
          idx_d        = 1'b0;
        end else if (byte_data < 8'hF8) begin
          status_vld_d = 1'b0;
        end
      end else if (status_vld_q) begin
        if (is_one_data(status_q[7:4]) || idx_q) begin
          exec  = chan_ok;
          idx_d = 1'b0;
          d0    = is_one_data(status_q[7:4]) ? byte_data[6:0] : data0_q;
          d1    = byte_data[6:0];
        end else begin
          data0_d = byte_data[6:0];
          idx_d   = 1'b1;
        end
      end
    end
  end

  logic             do_on, do_off, do_sus, do_all_off;
  logic             hit, free;
  logic [IDX_W-1:0] hit_idx, free_idx, old_idx, chosen;
  logic [AGE_W-1:0] old_age;

  // Voice allocation: retrigger, lowest free, else steal oldest
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) voices_d[i] = voices_q[i];
    sustain_d  = sustain_q;
    do_on      = exec && (status_q[7:4] == NOTE_ON) && (d1 != 7'd0);
    do_off     = exec && ((status_q[7:4] == NOTE_OFF) ||
                          ((status_q[7:4] == NOTE_ON) && (d1 == 7'd0)));
    do_sus     = exec && (status_q[7:4] == CTRL) && (d0 == CC_SUSTAIN);
    do_all_off = exec && (status_q[7:4] == CTRL) && (d0 == CC_ALL_NOTES_OFF);
    hit        = 1'b0;
    hit_idx    = '0;
    free       = 1'b0;
    free_idx   = '0;
    old_idx    = '0;
    old_age    = '0;

    for (int i = 0; i < NUM_VOICES; i++) begin
      if (voices_q[i].on && (voices_q[i].note == d0) && !hit) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!voices_q[i].on && !free) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (voices_q[i].age > old_age) begin
        old_age = voices_q[i].age;
        old_idx = IDX_W'(i);
      end
    end
    chosen = hit ? hit_idx : (free ? free_idx : old_idx);

    if (do_on) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (IDX_W'(i) == chosen) begin
          voices_d[i].on        = 1'b1;
          voices_d[i].sustained = 1'b0;
          voices_d[i].note      = d0;
          voices_d[i].vel       = d1;
          voices_d[i].age       = '0;
        end else if (voices_q[i].on && (voices_q[i].age != AGE_MAX)) begin
          voices_d[i].age = voices_q[i].age + 1'b1;
        end
      end
    end

    if (do_off) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (voices_q[i].on && (voices_q[i].note == d0)) begin
          if (sustain_q) voices_d[i].sustained = 1'b1;
          else           voices_d[i].on        = 1'b0;
        end
      end
    end

    if (do_sus) begin
      sustain_d = d1[6];
      if (sustain_q && !d1[6]) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (voices_q[i].sustained) begin
            voices_d[i].on        = 1'b0;
            voices_d[i].sustained = 1'b0;
          end
        end
      end
    end

    if (do_all_off) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        voices_d[i].on        = 1'b0;
        voices_d[i].sustained = 1'b0;
      end
    end
  end

  // Flatten the voice registers onto the output buses
  always_comb begin
    on_out       = '0;
    note_out     = '0;
    velocity_out = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      on_out[i]                           = voices_q[i].on;
      note_out[i*7 +: 7]                  = voices_q[i].note;
      velocity_out[i*VEL_WIDTH +: VEL_WIDTH] = voices_q[i].vel[6 -: VEL_WIDTH];
    end
    sustain_out = sustain_q;
  end

endmodule

// File: tb/tb_midi_poly_rx.sv
// Directed bench for midi_poly_rx: omni instance plus a channel-2 filtered instance.
module tb_midi_poly_rx;

  localparam int unsigned CLK_HZ = 500_000;
  localparam int unsigned BAUD   = 31_250;
  localparam int unsigned BIT    = CLK_HZ / BAUD;
  localparam int unsigned NV     = 8;
  localparam int unsigned VW     = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data_in = 1'b1;

  logic [NV-1:0]    on_o,  f_on;
  logic [NV*7-1:0]  note_o, f_note;
  logic [NV*VW-1:0] vel_o, f_vel;
  logic             sus_o, f_sus;
  logic             ferr_o, f_ferr;

  int n_checks = 0;
  int n_errs   = 0;
  int ferr_cnt = 0;
  int ferr_before;

  logic [NV*7-1:0]  exp_n;
  logic [NV*VW-1:0] exp_v;

  always #5 clk = ~clk;

  midi_poly_rx #(
    .INPUT_CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .NUM_VOICES(NV), .VEL_WIDTH(VW),
    .CHANNEL_FILTER_EN(0), .MIDI_CHANNEL(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .on_out(on_o), .note_out(note_o), .velocity_out(vel_o),
    .sustain_out(sus_o), .frame_err(ferr_o)
  );

  midi_poly_rx #(
    .INPUT_CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .NUM_VOICES(NV), .VEL_WIDTH(VW),
    .CHANNEL_FILTER_EN(1), .MIDI_CHANNEL(2)
  ) dut_f (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .on_out(f_on), .note_out(f_note), .velocity_out(f_vel),
    .sustain_out(f_sus), .frame_err(f_ferr)
  );

  // Count every cycle frame_err is high on the omni instance
  always @(negedge clk) if (ferr_o === 1'b1) ferr_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    data_in = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      data_in = b[i];
      repeat (BIT) @(posedge clk);
    end
    data_in = stop_ok;
    repeat (BIT) @(posedge clk);
    data_in = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    if (!stop_ok) repeat (12 * BIT) @(posedge clk);
  endtask

  task automatic send2(input logic [7:0] a, input logic [7:0] b);
    send_byte(a);
    send_byte(b);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (5) @(posedge clk);
    settle();
    check("rst_on",    64'(on_o),   64'h0);
    check("rst_note",  64'(note_o), 64'h0);
    check("rst_vel",   64'(vel_o),  64'h0);
    check("rst_sus",   64'(sus_o),  64'h0);
    check("rst_ferr",  64'(ferr_o), 64'h0);
    check("rst_f_on",  64'(f_on),   64'h0);
    check("rst_f_ferr",64'(f_ferr), 64'h0);
    @(posedge clk);
    rst_n = 1'b1;
    repeat (4 * BIT) @(posedge clk);

    // Basic note on / off; velocity 0x64 -> bits[6:4] = 3'b110
    send3(8'h90, 8'h3C, 8'h64);
    settle();
    check("on1_gate", 64'(on_o), 64'h01);
    check("on1_note", 64'(note_o[6:0]), 64'h3C);
    check("on1_vel",  64'(vel_o[2:0]), 64'h6);
    send3(8'h80, 8'h3C, 8'h00);
    settle();
    check("off1_gate", 64'(on_o), 64'h00);

    // Running status with an interleaved realtime byte; 0x40 -> 3'b100
    send3(8'h90, 8'h3C, 8'h40);
    send2(8'h3E, 8'h40);
    send_byte(8'hF8);
    send2(8'h40, 8'h40);
    settle();
    check("rs_gate",  64'(on_o), 64'h07);
    check("rs_notes", 64'(note_o[20:0]), 64'({7'h40, 7'h3E, 7'h3C}));
    check("rs_vel",   64'(vel_o[8:0]), 64'({3'd4, 3'd4, 3'd4}));
    send3(8'hB0, 8'h7B, 8'h00);
    settle();
    check("cc123_gate", 64'(on_o), 64'h00);

    // Fill all eight voices, then a ninth note steals voice 0
    send3(8'h90, 8'h30, 8'h64);
    for (int n = 1; n < 9; n++) send2(8'(8'h30 + n), 8'h64);
    settle();
    for (int i = 0; i < NV; i++) exp_n[i*7 +: 7] = 7'(7'h30 + i);
    exp_n[6:0] = 7'h38;
    check("steal_gate",  64'(on_o), 64'hFF);
    check("steal_notes", 64'(note_o), 64'(exp_n));

    // Retrigger note 0x31 on voice 1 with velocity 0x20 -> 3'b010
    send2(8'h31, 8'h20);
    settle();
    for (int i = 0; i < NV; i++) exp_v[i*VW +: VW] = 3'd6;
    exp_v[5:3] = 3'd2;
    check("retrig_gate",  64'(on_o), 64'hFF);
    check("retrig_notes", 64'(note_o), 64'(exp_n));
    check("retrig_vel",   64'(vel_o), 64'(exp_v));

    // Oldest is now voice 2 (voice 1 was just refreshed)
    send2(8'h39, 8'h64);
    settle();
    exp_n[20:14] = 7'h39;
    check("steal2_notes", 64'(note_o), 64'(exp_n));
    send3(8'hB0, 8'h7B, 8'h00);
    settle();
    check("cc123b_gate", 64'(on_o), 64'h00);

    // Sustain pedal holds a released note until the pedal lifts
    send3(8'hB0, 8'h40, 8'h7F);
    send3(8'h90, 8'h3C, 8'h64);
    send3(8'h80, 8'h3C, 8'h00);
    settle();
    check("sus_gate", 64'(on_o), 64'h01);
    check("sus_pedal", 64'(sus_o), 64'h1);
    send3(8'hB0, 8'h40, 8'h00);
    settle();
    check("sus_rel_gate", 64'(on_o), 64'h00);
    check("sus_rel_pedal", 64'(sus_o), 64'h0);

    // Bad stop bit: single frame_err pulse, byte discarded
    send3(8'h90, 8'h3C, 8'h64);
    settle();
    check("pre_ferr_cnt", 64'(ferr_cnt), 64'h0);
    ferr_before = ferr_cnt;
    send_byte(8'h3E, 1'b0);
    settle();
    check("ferr_pulse", 64'(ferr_cnt - ferr_before), 64'h1);
    check("ferr_gate",  64'(on_o), 64'h01);
    check("ferr_note",  64'(note_o[6:0]), 64'h3C);
    send2(8'h3E, 8'h64);
    settle();
    check("post_ferr_gate", 64'(on_o), 64'h03);
    check("post_ferr_note", 64'(note_o[13:7]), 64'h3E);

    // Reset in the middle of a byte
    data_in = 1'b0;
    repeat (4 * BIT) @(posedge clk);
    rst_n = 1'b0;
    data_in = 1'b1;
    repeat (3) @(posedge clk);
    settle();
    check("mid_rst_on",   64'(on_o),   64'h0);
    check("mid_rst_note", 64'(note_o), 64'h0);
    check("mid_rst_vel",  64'(vel_o),  64'h0);
    check("mid_rst_sus",  64'(sus_o),  64'h0);
    @(posedge clk);
    rst_n = 1'b1;
    repeat (4 * BIT) @(posedge clk);
    send2(8'h3E, 8'h64);
    settle();
    check("no_status_gate", 64'(on_o), 64'h00);
    send3(8'h90, 8'h3C, 8'h64);
    settle();
    check("after_rst_gate", 64'(on_o), 64'h01);
    check("after_rst_note", 64'(note_o[6:0]), 64'h3C);
    check("after_rst_vel",  64'(vel_o[2:0]), 64'h6);

    // Channel filter on the second instance (channel 2 only)
    send3(8'h91, 8'h3C, 8'h64);
    settle();
    check("filt_ch1_gate", 64'(f_on), 64'h00);
    check("omni_ch1_gate", 64'(on_o), 64'h01);
    send3(8'h92, 8'h3C, 8'h64);
    settle();
    check("filt_ch2_gate", 64'(f_on), 64'h01);
    check("filt_ch2_note", 64'(f_note[6:0]), 64'h3C);
    check("filt_ch2_vel",  64'(f_vel[2:0]), 64'h6);
    check("filt_sus",      64'(f_sus), 64'h0);
    send3(8'hB2, 8'h7B, 8'h00);
    settle();
    check("filt_alloff_gate", 64'(f_on), 64'h00);
    check("omni_alloff_gate", 64'(on_o), 64'h00);
    check("filt_ferr",        64'(f_ferr), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
